// File: rtl/seq_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_ctrl_pkg : shared types and helpers for the word-level scan ctrl     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } ctrl_state_t;

  // Bits needed to encode detector states S0..S<pat_len>.
  function automatic int det_state_w(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

  // a + b clamped to 2^w-1; the 33-bit sum keeps the carry for w up to 32.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_moore.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_det_moore : Moore pattern detector, MSB of PATTERN matched first     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module seq_det_moore
  import seq_ctrl_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic ovl,
  input  logic din,
  output logic hit
);

  localparam int SW = det_state_w(PAT_LEN);

  logic [SW-1:0] r_state;
  logic [SW-1:0] w_state_nxt;

  // Longest pattern prefix that is a suffix of (first s pattern bits, then b).
  // Bits are packed newest-in-LSB so prefixes and suffixes become shifts/masks.
  function automatic int kmp_next(input int s, input logic b);
    int v;
    int best;
    v    = ((int'(PATTERN) >> (PAT_LEN - s)) << 1) | int'(b);
    best = 0;
    for (int k = 1; k <= PAT_LEN; k++) begin
      if (k <= s + 1 && (v & ((1 << k) - 1)) == (int'(PATTERN) >> (PAT_LEN - k)))
        best = k;
    end
    return best;
  endfunction

  // Non-overlap discards the matched bits: the new bit is scanned as if from S0.
  always_comb begin
    w_state_nxt = r_state;
    if (en) begin
      if (r_state == SW'(PAT_LEN) && !ovl)
        w_state_nxt = SW'(kmp_next(0, din));
      else
        w_state_nxt = SW'(kmp_next(int'(r_state), din));
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) r_state <= '0;
    else              r_state <= w_state_nxt;
  end

  assign hit = (r_state == SW'(PAT_LEN));

endmodule
`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_scan_ctrl : serialises words into seq_det_moore and reports hits     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module seq_scan_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int                 WORD_W  = 8,
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 TOT_W   = 16,
  localparam int                CNT_W   = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              ovl_en,
  input  logic              flush,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_last,
  output logic              busy,
  output logic [TOT_W-1:0]  total_hits
);

  localparam int              IDX_W    = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  ctrl_state_t       r_state;
  logic [WORD_W-1:0] r_shreg;
  logic              r_ovl;
  logic [IDX_W-1:0]  r_idx;
  logic              w_det_hit;
  logic              w_det_en;
  logic              w_det_clr;
  logic [CNT_W-1:0]  w_word_cnt;

  assign w_det_en   = (r_state == SHIFT);
  assign w_det_clr  = flush && (r_state == IDLE);
  assign w_word_cnt = res_count + CNT_W'(w_det_hit);

  seq_det_moore #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_det (
    .clk   (clk),
    .reset (reset),
    .clr   (w_det_clr),
    .en    (w_det_en),
    .ovl   (r_ovl),
    .din   (r_shreg[WORD_W-1]),
    .hit   (w_det_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_ovl      <= 1'b0;
      r_idx      <= '0;
      res_count  <= '0;
      res_last   <= 1'b0;
      res_valid  <= 1'b0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      total_hits <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shreg   <= in_data;
            r_ovl     <= ovl_en;
            r_idx     <= '0;
            res_count <= '0;
            res_last  <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
          // At index 0 the detector still shows the previous word's last bit.
          if (r_idx != '0 && w_det_hit)
            res_count <= res_count + CNT_W'(1);
          if (r_idx == IDX_LAST) r_state <= DRAIN;
          else                   r_idx   <= r_idx + IDX_W'(1);
        end
        DRAIN: begin
          res_count  <= w_word_cnt;
          res_last   <= w_det_hit;
          total_hits <= TOT_W'(sat_add(32'(total_hits), 32'(w_word_cnt), TOT_W));
          res_valid  <= 1'b1;
          r_state    <= REPORT;
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_scan_ctrl : self-checking bench, reference model + directed cases |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_seq_scan_ctrl;

  localparam int         WORD_W  = 8;
  localparam int         PAT_LEN = 4;
  localparam logic [3:0] PATTERN = 4'b1101;
  localparam int         CNT_W   = $clog2(WORD_W + 1);

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              in_valid  = 1'b0;
  logic [WORD_W-1:0] in_data   = '0;
  logic              ovl_en    = 1'b0;
  logic              flush     = 1'b0;
  logic              res_ready = 1'b0;

  logic              in_ready, busy, res_valid, res_last;
  logic [CNT_W-1:0]  res_count;
  logic [15:0]       total_hits;
  logic              s_in_ready, s_busy, s_res_valid, s_res_last;
  logic [CNT_W-1:0]  s_res_count;
  logic [3:0]        s_total_hits;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .TOT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ovl_en(ovl_en), .flush(flush), .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_last(res_last), .busy(busy), .total_hits(total_hits));

  // Narrow total counter, driven in lockstep, to exercise saturation.
  seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .TOT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .ovl_en(ovl_en), .flush(flush), .res_valid(s_res_valid), .res_ready(res_ready),
    .res_count(s_res_count), .res_last(s_res_last), .busy(s_busy), .total_hits(s_total_hits));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Detector: a hit is the last PAT_LEN bits seen since the most recent
  // barrier spelling the pattern. Reset, flush and a non-overlap restart
  // after a hit each place a barrier.
  bit m_known = 1'b0, m_busy = 1'b0, m_rv = 1'b0, m_last = 1'b0, m_prev_hit = 1'b0;
  int m_age = 0, m_cnt = 0, m_tot16 = 0, m_tot4 = 0;
  bit hist[$];

  function automatic bit model_bit(input bit b, input bit ovl);
    int w;
    if (m_prev_hit && !ovl) hist.delete();
    hist.push_back(b);
    if (hist.size() > PAT_LEN) void'(hist.pop_front());
    w = 0;
    foreach (hist[j]) w = (w << 1) | int'(hist[j]);
    m_prev_hit = (hist.size() == PAT_LEN) && (w == int'(PATTERN));
    return m_prev_hit;
  endfunction

  always @(posedge clk) begin : model_p
    bit h;
    if (reset) begin
      m_known = 1'b1; m_busy = 1'b0; m_rv = 1'b0; m_age = 0;
      hist.delete(); m_prev_hit = 1'b0; m_tot16 = 0; m_tot4 = 0;
    end else if (m_known) begin
      if (!m_busy) begin
        if (flush) begin hist.delete(); m_prev_hit = 1'b0; end
        if (in_valid) begin
          m_busy = 1'b1; m_age = 0; m_cnt = 0; m_last = 1'b0;
          for (int i = WORD_W - 1; i >= 0; i--) begin
            h = model_bit(in_data[i], ovl_en);
            if (h) m_cnt++;
            m_last = h;
          end
        end
      end else if (m_rv) begin
        if (res_ready) begin m_busy = 1'b0; m_rv = 1'b0; end
      end else begin
        m_age++;
        if (m_age == WORD_W + 1) begin
          m_rv    = 1'b1;
          m_tot16 = (m_tot16 + m_cnt > 65535) ? 65535 : m_tot16 + m_cnt;
          m_tot4  = (m_tot4 + m_cnt > 15) ? 15 : m_tot4 + m_cnt;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("in_ready",     64'(in_ready),     64'(!m_busy));
      check("busy",         64'(busy),         64'(m_busy));
      check("res_valid",    64'(res_valid),    64'(m_rv));
      check("total_hits",   64'(total_hits),   64'(m_tot16));
      check("s_in_ready",   64'(s_in_ready),   64'(!m_busy));
      check("s_busy",       64'(s_busy),       64'(m_busy));
      check("s_res_valid",  64'(s_res_valid),  64'(m_rv));
      check("s_total_hits", 64'(s_total_hits), 64'(m_tot4));
      if (m_rv) begin
        check("res_count",   64'(res_count),   64'(m_cnt));
        check("res_last",    64'(res_last),    64'(m_last));
        check("s_res_count", 64'(s_res_count), 64'(m_cnt));
        check("s_res_last",  64'(s_res_last),  64'(m_last));
      end
    end
  end

  // ---------------- stimulus tasks (entered and left at posedge+1) ----------------
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] d, input bit o, input bit f, input int hold, input bit noise,
                      output int cnt, output bit last, output int lat);
    int k;
    cnt = -1; last = 1'b0; lat = 0;
    in_valid = 1'b1; in_data = d; ovl_en = o; flush = f;
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 50 cycles");
      in_valid = 1'b0; flush = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; lat = 1;
    while (!res_valid && lat < 40) begin
      if (noise) begin
        in_valid = 1'($urandom); in_data = 8'($urandom);
        flush = 1'($urandom); res_ready = 1'($urandom);
      end
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0; flush = 1'b0; res_ready = 1'b0;
    if (!res_valid) begin
      n_checks++; n_fail++;
      $display("FAIL result_timeout: got res_valid=0, expected 1 within 40 cycles");
      return;
    end
    cnt = int'(res_count); last = res_last;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_res_valid", 64'(res_valid), 64'(1));
      check("hold_in_ready",  64'(in_ready),  64'(0));
      check("hold_res_count", 64'(res_count), 64'(cnt));
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic abort_word(input logic [7:0] d, input bit o, input int at_bit);
    in_valid = 1'b1; in_data = d; ovl_en = o; flush = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (at_bit) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_in_ready",   64'(in_ready),     64'(1));
    check("abort_busy",       64'(busy),         64'(0));
    check("abort_res_valid",  64'(res_valid),    64'(0));
    check("abort_total",      64'(total_hits),   64'(0));
    check("abort_s_total",    64'(s_total_hits), 64'(0));
    check("abort_res_count",  64'(res_count),    64'(0));
  endtask

  // ---------------- directed cases, then random traffic ----------------
  initial begin : main_p
    int  c, c2, lat, r, gap;
    bit  l, l2;
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    check("rst_in_ready",  64'(in_ready),   64'(1));
    check("rst_busy",      64'(busy),       64'(0));
    check("rst_res_valid", 64'(res_valid),  64'(0));
    check("rst_res_count", 64'(res_count),  64'(0));
    check("rst_res_last",  64'(res_last),   64'(0));
    check("rst_total",     64'(total_hits), 64'(0));

    xfer(8'b1101_1010, 1'b1, 1'b0, 0, 1'b0, c, l, lat);
    check("t1_count",   64'(c),          64'(2));
    check("t1_last",    64'(l),          64'(0));
    check("t1_latency", 64'(lat),        64'(10));
    check("t1_total",   64'(total_hits), 64'(2));

    xfer(8'b1101_1010, 1'b0, 1'b1, 0, 1'b0, c, l, lat);
    check("t2_count", 64'(c), 64'(1));
    check("t2_last",  64'(l), 64'(0));

    do_reset();
    xfer(8'b0000_0011, 1'b1, 1'b0, 0, 1'b0, c, l, lat);
    xfer(8'b0100_0000, 1'b1, 1'b0, 0, 1'b0, c2, l2, lat);
    check("t3_count_a", 64'(c),          64'(0));
    check("t3_count_b", 64'(c2),         64'(1));
    check("t3_total",   64'(total_hits), 64'(1));
    xfer(8'b0000_0011, 1'b1, 1'b0, 0, 1'b0, c, l, lat);
    do_flush();
    xfer(8'b0100_0000, 1'b1, 1'b0, 0, 1'b0, c2, l2, lat);
    check("t3f_count_a", 64'(c),  64'(0));
    check("t3f_count_b", 64'(c2), 64'(0));

    xfer(8'b0000_1101, 1'b1, 1'b0, 5, 1'b0, c, l, lat);
    check("t4_count", 64'(c), 64'(1));
    check("t4_last",  64'(l), 64'(1));

    abort_word(8'b1111_1111, 1'b1, 3);
    xfer(8'b1101_0000, 1'b1, 1'b0, 0, 1'b0, c, l, lat);
    check("t5_count", 64'(c), 64'(1));

    do_reset();
    for (int w = 0; w < 8; w++) begin
      xfer(8'b1101_1101, 1'b1, 1'b0, 0, 1'b0, c, l, lat);
      check("t6_count", 64'(c), 64'(2));
      if (w == 6) check("t6_s_total_7", 64'(s_total_hits), 64'(14));
    end
    check("t6_s_total", 64'(s_total_hits), 64'(15));
    check("t6_total",   64'(total_hits),   64'(16));

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 39));
      if (r == 0) begin
        do_reset();
      end else if (r == 1) begin
        abort_word(8'($urandom), 1'($urandom), int'($urandom_range(0, 7)));
      end else begin
        gap = int'($urandom_range(0, 2));
        repeat (gap) begin
          flush = ($urandom_range(0, 3) == 0);
          @(posedge clk); #1;
        end
        flush = 1'b0;
        xfer(8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 3)), 1'b1, c, l, lat);
        check("rand_latency", 64'(lat), 64'(WORD_W + 2));
      end
    end

    repeat (2) begin @(posedge clk); #1; end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog_p
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
